// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: shifter state encoding and counter-width helper shared by the serializer files
package piso_serializer_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_GAP   = 2'b10
   } state_t;

   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// ser_hold_reg: one-word holding register with full flag, lets the next word wait behind the shifter
module ser_hold_reg
   import piso_serializer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             load,
   input  logic             unload,
   output logic [WIDTH-1:0] q,
   output logic             full
);

   // Full flag: set on load, cleared on unload; a simultaneous load keeps it set
   always_ff @(posedge clk or posedge rst) begin
      if (rst) full <= 1'b0;
      else     full <= load | (full & ~unload);
   end

   // Data word: only meaningful while full, so it carries no reset
   always_ff @(posedge clk) begin
      if (load) q <= d;
   end

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out front end with one-word hold buffer and optional inter-word gap
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter bit   MSB_FIRST  = 1'b1,
   parameter logic IDLE_BIT   = 1'b0,
   parameter int   GAP_CYCLES = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             word_start,
   output logic             word_last,
   output logic             busy
);

   localparam int BW = cnt_w(WIDTH);
   localparam int GW = cnt_w(GAP_CYCLES);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   state_t           state, state_nxt;
   logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
   logic [GW-1:0]    gap_cnt, gap_cnt_nxt;
   logic [WIDTH-1:0] sr, sr_nxt, src, shifted, hold_q;
   logic             head, hold_full, accept, last_bit, more, gap_done, free;
   logic             from_hold, from_din, load, hold_load, shifting;
   logic             ser_out_nxt, ser_valid_nxt, word_start_nxt, word_last_nxt;

   // The shifter can take a new word when idle, on the final gap cycle, or on its last bit when no gap follows
   assign din_ready = ~rst & ~hold_full;
   assign accept    = din_valid & din_ready;
   assign last_bit  = (state == S_SHIFT) && (bit_cnt == BIT_LAST);
   assign more      = (state == S_SHIFT) && !last_bit;
   assign gap_done  = (state == S_GAP) && (gap_cnt == GAP_LAST);
   assign free      = (state == S_IDLE) || (last_bit && (GAP_CYCLES == 0)) || gap_done;
   assign from_hold = free & hold_full;
   assign from_din  = free & ~hold_full & accept;
   assign load      = from_hold | from_din;
   assign hold_load = accept & ~from_din;
   assign shifting  = load | more;
   assign src       = load ? (hold_full ? hold_q : din) : sr;
   assign busy      = (state != S_IDLE) | hold_full;

   generate
      if (MSB_FIRST) begin : g_msb
         assign head    = src[WIDTH-1];
         assign shifted = {src[WIDTH-2:0], 1'b0};
      end else begin : g_lsb
         assign head    = src[0];
         assign shifted = {1'b0, src[WIDTH-1:1]};
      end
   endgenerate

   ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
      .clk    (clk),
      .rst    (rst),
      .d      (din),
      .load   (hold_load),
      .unload (from_hold),
      .q      (hold_q),
      .full   (hold_full)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next state: keep shifting while bits remain or a word loads, otherwise rest in GAP or IDLE
   always_comb begin
      state_nxt = shifting ? S_SHIFT :
                  ((last_bit && (GAP_CYCLES != 0)) || ((state == S_GAP) && !gap_done)) ? S_GAP : S_IDLE;
   end

   // Next values of the shifter, counters and serial outputs; a loaded word shows its first bit at once
   always_comb begin
      sr_nxt         = shifting ? shifted : '0;
      bit_cnt_nxt    = more ? bit_cnt + 1'b1 : '0;
      gap_cnt_nxt    = ((state == S_GAP) && !gap_done) ? gap_cnt + 1'b1 : '0;
      ser_out_nxt    = shifting ? head : IDLE_BIT;
      ser_valid_nxt  = shifting;
      word_start_nxt = load;
      word_last_nxt  = shifting && (bit_cnt_nxt == BIT_LAST);
   end

   // Datapath and registered serial outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr         <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         ser_out    <= IDLE_BIT;
         ser_valid  <= 1'b0;
         word_start <= 1'b0;
         word_last  <= 1'b0;
      end else begin
         sr         <= sr_nxt;
         bit_cnt    <= bit_cnt_nxt;
         gap_cnt    <= gap_cnt_nxt;
         ser_out    <= ser_out_nxt;
         ser_valid  <= ser_valid_nxt;
         word_start <= word_start_nxt;
         word_last  <= word_last_nxt;
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed and randomised checks of two serializer configurations
module tb_piso_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] din [2];
   logic [1:0]   din_valid, din_ready, ser_out, ser_valid, word_start, word_last, busy;
   logic [7:0]   stream_a;
   int           tests = 0;
   int           fails = 0;

   always #5 clk = ~clk;

   // Instance 0: MSB first, IDLE_BIT 0, continuous. Instance 1: LSB first, IDLE_BIT 1, 2-cycle gap.
   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP_CYCLES(0)) u_a (
      .clk(clk), .rst(rst), .din(din[0]), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
      .ser_out(ser_out[0]), .ser_valid(ser_valid[0]), .word_start(word_start[0]),
      .word_last(word_last[0]), .busy(busy[0])
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1), .GAP_CYCLES(2)) u_b (
      .clk(clk), .rst(rst), .din(din[1]), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
      .ser_out(ser_out[1]), .ser_valid(ser_valid[1]), .word_start(word_start[1]),
      .word_last(word_last[1]), .busy(busy[1])
   );

   function automatic bit msb_of(input int i);
      return i == 0;
   endfunction

   function automatic int gap_of(input int i);
      return (i == 0) ? 0 : 2;
   endfunction

   function automatic logic idle_of(input int i);
      return (i == 0) ? 1'b0 : 1'b1;
   endfunction

   task automatic test_reset();
      din_valid = 2'b00;
      din[0] = '0;
      din[1] = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if (din_ready !== 2'b00 || ser_valid !== 2'b00 || word_start !== 2'b00 || word_last !== 2'b00) begin
         fails++;
         $display("FAIL reset_hold: ready=%b valid=%b start=%b last=%b, required 00 00 00 00",
                  din_ready, ser_valid, word_start, word_last);
      end
      tests++;
      if (ser_out !== 2'b10) begin
         fails++;
         $display("FAIL reset_idle_bit: ser_out=%b, required 10", ser_out);
      end
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (din_ready !== 2'b11 || busy !== 2'b00 || ser_valid !== 2'b00 || ser_out !== 2'b10) begin
         fails++;
         $display("FAIL reset_release: ready=%b busy=%b valid=%b ser_out=%b, required 11 00 00 10",
                  din_ready, busy, ser_valid, ser_out);
      end
   endtask

   task automatic test_msb_word();
      logic [7:0] pat;
      pat = 8'hE0;
      din[0] = 8'hE0;
      din_valid[0] = 1'b1;
      @(negedge clk);
      din_valid[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tests++;
         if (ser_valid[0] !== 1'b1 || ser_out[0] !== pat[7-k] || word_start[0] !== (k == 0) ||
             word_last[0] !== (k == 7)) begin
            fails++;
            $display("FAIL msb_bit%0d: valid=%b out=%b start=%b last=%b, required 1 %b %b %b",
                     k, ser_valid[0], ser_out[0], word_start[0], word_last[0], pat[7-k], k == 0, k == 7);
         end
         stream_a[7-k] = ser_out[0];
         @(negedge clk);
      end
      tests++;
      if (ser_valid[0] !== 1'b0 || ser_out[0] !== 1'b0 || busy[0] !== 1'b0) begin
         fails++;
         $display("FAIL msb_after: valid=%b out=%b busy=%b, required 0 0 0", ser_valid[0], ser_out[0], busy[0]);
      end
   endtask

   task automatic test_lsb_word();
      logic [7:0] pat, stream_b;
      pat = 8'hE0;
      din[1] = 8'h07;
      din_valid[1] = 1'b1;
      @(negedge clk);
      din_valid[1] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tests++;
         if (ser_valid[1] !== 1'b1 || ser_out[1] !== pat[7-k] || word_start[1] !== (k == 0) ||
             word_last[1] !== (k == 7)) begin
            fails++;
            $display("FAIL lsb_bit%0d: valid=%b out=%b start=%b last=%b, required 1 %b %b %b",
                     k, ser_valid[1], ser_out[1], word_start[1], word_last[1], pat[7-k], k == 0, k == 7);
         end
         stream_b[7-k] = ser_out[1];
         @(negedge clk);
      end
      tests++;
      if (stream_b !== stream_a) begin
         fails++;
         $display("FAIL lsb_vs_msb_stream: lsb stream=%b, required msb stream %b", stream_b, stream_a);
      end
      tests++;
      if (ser_valid[1] !== 1'b0 || ser_out[1] !== 1'b1) begin
         fails++;
         $display("FAIL lsb_after: valid=%b out=%b, required 0 1", ser_valid[1], ser_out[1]);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [23:0] exp24;
      int          idx, nbits, first, lastc;
      bit          acc, saw_low;
      exp24 = 24'hA53CFF;
      idx = 0;
      nbits = 0;
      first = -1;
      lastc = -1;
      saw_low = 1'b0;
      din[0] = exp24[23 -: 8];
      din_valid[0] = 1'b1;
      acc = din_ready[0];
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ser_valid[0] === 1'b1) begin
            if (first < 0) first = c;
            lastc = c;
            if (nbits < 24) begin
               tests++;
               if (ser_out[0] !== exp24[23-nbits]) begin
                  fails++;
                  $display("FAIL b2b_bit%0d: out=%b, required %b", nbits, ser_out[0], exp24[23-nbits]);
               end
            end
            nbits++;
         end
         if (din_ready[0] === 1'b0) saw_low = 1'b1;
         if (acc) begin
            idx++;
            if (idx < 3) din[0] = exp24[23-8*idx -: 8];
            else din_valid[0] = 1'b0;
         end
         acc = din_valid[0] & din_ready[0];
      end
      tests++;
      if (nbits != 24 || lastc - first != 23) begin
         fails++;
         $display("FAIL b2b_no_bubble: bits=%0d span=%0d, required 24 24", nbits, lastc - first + 1);
      end
      tests++;
      if (!saw_low) begin
         fails++;
         $display("FAIL b2b_ready_drop: din_ready never 0, required 0 while hold full");
      end
   endtask

   task automatic test_gap();
      logic [15:0] w2;
      int          idx, nb, lastc, gapc;
      bit          acc;
      w2 = 16'h5AC3;
      idx = 0;
      nb = 0;
      lastc = -1;
      gapc = -1;
      din[1] = w2[15:8];
      din_valid[1] = 1'b1;
      acc = din_ready[1];
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ser_valid[1] === 1'b1) begin
            if (nb < 16) begin
               tests++;
               if (ser_out[1] !== w2[8*(1-nb/8) + nb%8]) begin
                  fails++;
                  $display("FAIL gap_bit%0d: out=%b, required %b", nb, ser_out[1], w2[8*(1-nb/8) + nb%8]);
               end
            end
            if (word_start[1] === 1'b1 && lastc >= 0) gapc = c - lastc - 1;
            if (word_last[1] === 1'b1) lastc = c;
            nb++;
         end else if (lastc >= 0 && gapc < 0) begin
            tests++;
            if (ser_out[1] !== 1'b1 || word_start[1] !== 1'b0) begin
               fails++;
               $display("FAIL gap_idle: out=%b start=%b, required 1 0", ser_out[1], word_start[1]);
            end
         end
         if (acc) begin
            idx++;
            if (idx < 2) din[1] = w2[7:0];
            else din_valid[1] = 1'b0;
         end
         acc = din_valid[1] & din_ready[1];
      end
      tests++;
      if (gapc != 2 || nb != 16) begin
         fails++;
         $display("FAIL gap_len: gap=%0d bits=%0d, required 2 16", gapc, nb);
      end
   endtask

   task automatic test_async_reset();
      din[0] = 8'hFF;
      din_valid[0] = 1'b1;
      @(negedge clk);
      din[0] = 8'h81;
      @(negedge clk);
      din_valid[0] = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (ser_valid[0] !== 1'b1 || ser_out[0] !== 1'b1 || din_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
         fails++;
         $display("FAIL arst_before: valid=%b out=%b ready=%b busy=%b, required 1 1 0 1",
                  ser_valid[0], ser_out[0], din_ready[0], busy[0]);
      end
      #2 rst = 1'b1;
      #1;
      tests++;
      if (ser_valid !== 2'b00 || ser_out !== 2'b10 || word_start !== 2'b00 || word_last !== 2'b00 ||
          busy !== 2'b00 || din_ready !== 2'b00) begin
         fails++;
         $display("FAIL arst_immediate: valid=%b out=%b start=%b last=%b busy=%b ready=%b, required 00 10 00 00 00 00",
                  ser_valid, ser_out, word_start, word_last, busy, din_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         tests++;
         if (ser_valid[0] !== 1'b0 || busy[0] !== 1'b0 || din_ready[0] !== 1'b1 || ser_out[0] !== 1'b0) begin
            fails++;
            $display("FAIL arst_after c%0d: valid=%b busy=%b ready=%b out=%b, required 0 0 1 0",
                     c, ser_valid[0], busy[0], din_ready[0], ser_out[0]);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] q0 [$];
      logic [7:0] q1 [$];
      logic [7:0] fw;
      int         cnt [2], run [2], acc_n [2];
      bit         pend [2], seen [2];
      int         cyc, qs;
      bit         done, expb;
      for (int i = 0; i < 2; i++) begin
         cnt[i] = 0;
         run[i] = 0;
         acc_n[i] = 0;
         pend[i] = 1'b0;
         seen[i] = 1'b0;
      end
      cyc = 0;
      done = 1'b0;
      while (!done && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < 2; i++) begin
            qs = (i == 0) ? q0.size() : q1.size();
            fw = (qs == 0) ? 8'h00 : ((i == 0) ? q0[0] : q1[0]);
            if (ser_valid[i] === 1'b1) begin
               tests++;
               if (qs == 0) begin
                  fails++;
                  $display("FAIL sb_extra_bit dut%0d: bit emitted with no word outstanding, required none", i);
               end else begin
                  expb = msb_of(i) ? fw[7-cnt[i]] : fw[cnt[i]];
                  if (ser_out[i] !== expb || word_start[i] !== (cnt[i] == 0) || word_last[i] !== (cnt[i] == 7)) begin
                     fails++;
                     $display("FAIL sb_bit dut%0d word=%h bit%0d: out=%b start=%b last=%b, required %b %b %b",
                              i, fw, cnt[i], ser_out[i], word_start[i], word_last[i], expb, cnt[i] == 0, cnt[i] == 7);
                  end
               end
               if (cnt[i] == 0 && seen[i]) begin
                  tests++;
                  if (pend[i] ? (run[i] != gap_of(i)) : (run[i] < gap_of(i))) begin
                     fails++;
                     $display("FAIL sb_gap dut%0d: idle run=%0d pending=%0d, required %0d", i, run[i], pend[i], gap_of(i));
                  end
               end
               run[i] = 0;
               cnt[i]++;
               if (cnt[i] == 8) begin
                  cnt[i] = 0;
                  seen[i] = 1'b1;
                  if (i == 0) begin
                     if (q0.size() > 0) void'(q0.pop_front());
                     pend[i] = q0.size() > 0;
                  end else begin
                     if (q1.size() > 0) void'(q1.pop_front());
                     pend[i] = q1.size() > 0;
                  end
               end
            end else begin
               run[i]++;
               tests++;
               if (ser_out[i] !== idle_of(i) || word_start[i] !== 1'b0 || word_last[i] !== 1'b0) begin
                  fails++;
                  $display("FAIL sb_idle dut%0d: out=%b start=%b last=%b, required %b 0 0",
                           i, ser_out[i], word_start[i], word_last[i], idle_of(i));
               end
            end
         end
         for (int i = 0; i < 2; i++) begin
            din[i] = 8'($urandom);
            din_valid[i] = (acc_n[i] < 1000) && ($urandom_range(0, 99) < 60);
            if (din_valid[i] && din_ready[i] === 1'b1) begin
               acc_n[i]++;
               if (i == 0) q0.push_back(din[i]);
               else q1.push_back(din[i]);
            end
         end
         done = (acc_n[0] == 1000) && (acc_n[1] == 1000) && (q0.size() == 0) && (q1.size() == 0) &&
                (busy === 2'b00);
      end
      din_valid = 2'b00;
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL sb_drain: accepted=%0d/%0d outstanding=%0d/%0d busy=%b after %0d cycles, required all emitted",
                  acc_n[0], acc_n[1], q0.size(), q1.size(), busy, cyc);
      end
   endtask

   initial begin
      test_reset();
      test_msb_word();
      test_lsb_word();
      test_back_to_back();
      test_gap();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
